// File: rtl/dm_cache_pkg.sv
// Shared types and constants for the direct-mapped write-through cache controller.
package dm_cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MEM_RD,
      MEM_WR,
      RESP
   } state_t;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   function automatic int tag_width(input int addr_w, input int idx_w);
      return addr_w - idx_w;
   endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational read,
// synchronous fill/update, single-cycle flush of all valid bits.
module dm_cache_array #(
   parameter int IDX_W  = 3,
   parameter int TAG_W  = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              rd_valid,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              flush
);

   localparam int LINES = 1 << IDX_W;

   logic [LINES-1:0]  valid;
   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [DATA_W-1:0] data_mem [LINES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (flush) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   // NOTE: tag/data storage has no reset; the valid bits alone qualify it,
   // so these arrays stay plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tag_mem[rd_idx];
   assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with a
// req/ack memory port and saturating hit/miss counters.
module dm_cache_ctrl
   import dm_cache_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int IDX_W  = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_rw,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_flush,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              mem_req,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int TAG_W = tag_width(ADDR_W, IDX_W);

   state_t state, state_nxt;

   logic              req_rw;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [IDX_W-1:0]  req_idx;
   logic [TAG_W-1:0]  req_tag;

   logic              line_valid;
   logic [TAG_W-1:0]  line_tag;
   logic [DATA_W-1:0] line_data;
   logic              hit;

   logic              arr_wr_en;
   logic [DATA_W-1:0] arr_wr_data;
   logic              arr_flush;
   logic              take_req;
   logic              hit_inc;
   logic              miss_inc;
   logic              rdata_ld;
   logic [DATA_W-1:0] rdata_nxt;

   assign req_idx = req_addr[IDX_W-1:0];
   assign req_tag = req_addr[ADDR_W-1:IDX_W];
   assign hit     = line_valid && (line_tag == req_tag);

   dm_cache_array #(
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (req_idx),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .rd_data  (line_data),
      .wr_en    (arr_wr_en),
      .wr_idx   (req_idx),
      .wr_tag   (req_tag),
      .wr_data  (arr_wr_data),
      .flush    (arr_flush)
   );

   // NOTE: every clocked block uses <= so all registers sample pre-edge values,
   // independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:           if (cpu_req && !cpu_flush) state_nxt = LOOKUP;
         LOOKUP: begin
            if (req_rw == RW_READ) state_nxt = hit ? RESP : MEM_RD;
            else                   state_nxt = MEM_WR;
         end
         MEM_RD, MEM_WR: if (mem_ack) state_nxt = RESP;
         RESP:           state_nxt = IDLE;
         default:        state_nxt = IDLE;
      endcase
   end

   // NOTE: each output gets a default before the case, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      cpu_ready   = 1'b0;
      mem_req     = 1'b0;
      mem_rw      = RW_READ;
      arr_wr_en   = 1'b0;
      arr_wr_data = req_wdata;
      arr_flush   = 1'b0;
      take_req    = 1'b0;
      hit_inc     = 1'b0;
      miss_inc    = 1'b0;
      rdata_ld    = 1'b0;
      rdata_nxt   = line_data;
      unique case (state)
         IDLE: begin
            arr_flush = cpu_flush;
            take_req  = cpu_req && !cpu_flush;
         end
         LOOKUP: begin
            hit_inc  = hit;
            miss_inc = !hit;
            if (req_rw == RW_READ) rdata_ld  = hit;
            else                   arr_wr_en = hit;
         end
         MEM_RD: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               arr_wr_en   = 1'b1;
               arr_wr_data = mem_rdata;
               rdata_ld    = 1'b1;
               rdata_nxt   = mem_rdata;
            end
         end
         MEM_WR: begin
            mem_req = 1'b1;
            mem_rw  = RW_WRITE;
         end
         RESP:    cpu_ready = 1'b1;
         default: ;
      endcase
   end

   // Memory address/data come straight from the request registers, so they
   // stay stable for the whole handshake.
   assign mem_addr  = req_addr;
   assign mem_wdata = req_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_rw    <= RW_READ;
         req_addr  <= '0;
         req_wdata <= '0;
         cpu_rdata <= '0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
      end else begin
         if (take_req) begin
            req_rw    <= cpu_rw;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
         end
         if (rdata_ld) cpu_rdata <= rdata_nxt;
         if (hit_inc && (hit_cnt != '1))   hit_cnt  <= hit_cnt + 1'b1;
         if (miss_inc && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: directed scenarios plus randomized
// traffic against a line-array/memory reference model.
module tb_dm_cache_ctrl;
   import dm_cache_pkg::*;

   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 8;
   localparam int IDX_W   = 3;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cpu_req, cpu_rw, cpu_flush, cpu_ready;
   logic [ADDR_W-1:0] cpu_addr, mem_addr;
   logic [DATA_W-1:0] cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
   logic              mem_req, mem_rw, mem_ack;
   logic [CNT_W-1:0]  hit_cnt, miss_cnt;

   dm_cache_ctrl #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_req   (cpu_req),
      .cpu_rw    (cpu_rw),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_flush (cpu_flush),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .mem_req   (mem_req),
      .mem_rw    (mem_rw),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: one entry per line plus a flat backing memory.
   bit          m_valid [8];
   logic [4:0]  m_tag   [8];
   logic [7:0]  m_data  [8];
   logic [7:0]  mem     [256];
   int          exp_hit, exp_miss;
   logic [7:0]  exp_rdata;
   bit          chk_on;

   int n_tests, n_fail;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= CNT_MAX) ? CNT_MAX : v + 1;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
   endtask

   // Per-cycle comparison of the architecturally visible state.
   always @(posedge clk) begin
      #2;
      if (chk_on) begin
         check("hit_cnt", 32'(hit_cnt), exp_hit);
         check("miss_cnt", 32'(miss_cnt), exp_miss);
         check("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata));
      end
   end

   task automatic do_flush();
      @(negedge clk);
      mem_ack   = 1'b0;
      cpu_flush = 1'b1;
      model_clear();
      @(negedge clk);
      cpu_flush = 1'b0;
   endtask

   task automatic do_op(input logic rw, input logic [7:0] addr, input logic [7:0] wdata,
                        input int wait_c, input bit pre_flush, input bit mid_flush,
                        input bit mid_reset, input bit spurious,
                        output int lat, output int mem_cycles);
      logic [2:0] idx;
      logic [4:0] tag;
      bit         hit, need_mem, done, aborted;
      int         exp_lat;
      idx = addr[2:0];
      tag = addr[7:3];
      @(negedge clk);
      mem_ack   = 1'b0;
      cpu_req   = 1'b1;
      cpu_rw    = rw;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      if (pre_flush) begin
         cpu_flush = 1'b1;
         model_clear();
         @(negedge clk);
         cpu_flush = 1'b0;
      end
      hit      = m_valid[idx] && (m_tag[idx] == tag);
      need_mem = !hit || (rw == RW_WRITE);
      exp_lat  = (hit && rw == RW_READ) ? 2 : 3 + wait_c;
      lat = 0; mem_cycles = 0; done = 0; aborted = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
         cpu_flush = 1'b0;
         mem_ack   = 1'b0;
         if (lat == 1) begin
            if (hit) exp_hit = sat_inc(exp_hit);
            else     exp_miss = sat_inc(exp_miss);
            if (hit && rw == RW_READ)  exp_rdata = m_data[idx];
            if (hit && rw == RW_WRITE) m_data[idx] = wdata;
         end
         if (cpu_ready) begin
            done = 1;
         end else if (mem_req) begin
            mem_cycles++;
            check("mem_addr", 32'(mem_addr), 32'(addr));
            check("mem_rw", 32'(mem_rw), 32'(rw));
            if (rw == RW_WRITE) check("mem_wdata", 32'(mem_wdata), 32'(wdata));
            if (mid_reset && mem_cycles == 1) begin
               rst_n = 1'b0;
               #1;
               check("reset_drops_mem_req", 32'(mem_req), 32'd0);
               check("reset_clears_mem_addr", 32'(mem_addr), 32'd0);
               cpu_req = 1'b0;
               model_clear();
               exp_hit = 0; exp_miss = 0; exp_rdata = 8'h00;
               @(negedge clk);
               @(negedge clk);
               rst_n   = 1'b1;
               aborted = 1;
               done    = 1;
            end else begin
               if (mid_flush && mem_cycles == 1) cpu_flush = 1'b1;
               if (mem_cycles == wait_c + 1) begin
                  mem_ack = 1'b1;
                  if (rw == RW_READ) begin
                     mem_rdata    = mem[addr];
                     exp_rdata    = mem[addr];
                     m_valid[idx] = 1'b1;
                     m_tag[idx]   = tag;
                     m_data[idx]  = mem[addr];
                  end else begin
                     mem_rdata = 8'($urandom);
                     mem[addr] = wdata;
                  end
               end
            end
         end
      end
      cpu_req = 1'b0;
      if (!aborted) begin
         check("latency", 32'(lat), 32'(exp_lat));
         check("mem_cycles", 32'(mem_cycles), need_mem ? 32'(wait_c + 1) : 32'd0);
         @(negedge clk);
         check("ready_one_cycle", 32'(cpu_ready), 32'd0);
         if (spurious) begin
            mem_ack   = 1'b1;
            mem_rdata = 8'($urandom);
         end
      end
   endtask

   initial begin
      int lat, mc;
      n_tests = 0; n_fail = 0; chk_on = 0;
      exp_hit = 0; exp_miss = 0; exp_rdata = 8'h00;
      model_clear();
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'h13] = 8'hA5;
      rst_n = 1'b0; cpu_req = 1'b0; cpu_rw = RW_READ; cpu_addr = '0; cpu_wdata = '0;
      cpu_flush = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_rw", 32'(mem_rw), 32'd1);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
      check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
      rst_n  = 1'b1;
      chk_on = 1;

      // Read miss with two memory wait cycles.
      do_op(RW_READ, 8'h13, 8'h00, 2, 0, 0, 0, 0, lat, mc);
      check("t1_mem_cycles", 32'(mc), 32'd3);
      check("t1_latency", 32'(lat), 32'd5);
      check("t1_rdata", 32'(cpu_rdata), 32'hA5);
      check("t1_miss_cnt", 32'(miss_cnt), 32'd1);
      // Read hit.
      do_op(RW_READ, 8'h13, 8'h00, 0, 0, 0, 0, 0, lat, mc);
      check("t2_latency", 32'(lat), 32'd2);
      check("t2_mem_cycles", 32'(mc), 32'd0);
      check("t2_hit_cnt", 32'(hit_cnt), 32'd1);
      // Write hit goes through to memory, then read hit returns new data.
      do_op(RW_WRITE, 8'h13, 8'h3C, 1, 0, 0, 0, 1, lat, mc);
      check("t3_write_mem_cycles", 32'(mc), 32'd2);
      do_op(RW_READ, 8'h13, 8'h00, 0, 0, 0, 0, 0, lat, mc);
      check("t3_read_rdata", 32'(cpu_rdata), 32'h3C);
      check("t3_read_mem_cycles", 32'(mc), 32'd0);
      check("t3_hit_cnt", 32'(hit_cnt), 32'd3);
      // Write miss does not allocate.
      do_op(RW_WRITE, 8'h2B, 8'h77, 0, 0, 0, 0, 0, lat, mc);
      do_op(RW_READ, 8'h2B, 8'h00, 0, 0, 0, 0, 0, lat, mc);
      check("t4_rdata", 32'(cpu_rdata), 32'h77);
      check("t4_miss_cnt", 32'(miss_cnt), 32'd3);
      // Same-index conflict evicts.
      do_op(RW_READ, 8'h13, 8'h00, 0, 0, 0, 0, 0, lat, mc);
      do_op(RW_READ, 8'h1B, 8'h00, 0, 0, 0, 0, 0, lat, mc);
      do_op(RW_READ, 8'h13, 8'h00, 0, 0, 0, 0, 0, lat, mc);
      check("t5_latency", 32'(lat), 32'd3);
      check("t5_rdata", 32'(cpu_rdata), 32'h3C);
      check("t5_miss_cnt", 32'(miss_cnt), 32'd6);
      // Flush in IDLE invalidates, and wins over a simultaneous request.
      do_flush();
      do_op(RW_READ, 8'h13, 8'h00, 0, 0, 0, 0, 0, lat, mc);
      check("t6_flush_miss", 32'(mc), 32'd1);
      do_op(RW_READ, 8'h13, 8'h00, 0, 1, 0, 0, 0, lat, mc);
      check("t6_flush_req_miss", 32'(mc), 32'd1);
      // Flush during a memory wait is ignored.
      do_op(RW_READ, 8'h1B, 8'h00, 2, 0, 1, 0, 0, lat, mc);
      do_op(RW_READ, 8'h1B, 8'h00, 0, 0, 0, 0, 0, lat, mc);
      check("t7_hit_after_mid_flush", 32'(lat), 32'd2);
      // Reset during a memory read wait.
      do_op(RW_READ, 8'h13, 8'h00, 3, 0, 0, 1, 0, lat, mc);
      check("t8_hit_cnt_zero", 32'(hit_cnt), 32'd0);
      check("t8_miss_cnt_zero", 32'(miss_cnt), 32'd0);
      do_op(RW_READ, 8'h13, 8'h00, 0, 0, 0, 0, 0, lat, mc);
      check("t8_miss_latency", 32'(lat), 32'd3);
      check("t8_miss_cnt", 32'(miss_cnt), 32'd1);

      // Randomized traffic; small tag range keeps hits frequent and both
      // counters reach saturation.
      for (int n = 0; n < 150; n++) begin
         logic [7:0] a;
         a = {3'b000, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
         do_op(1'($urandom), a, 8'($urandom), int'($urandom_range(0, 3)),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0), lat, mc);
      end
      @(negedge clk);
      mem_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk_on = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller between the CPU-side request port and the external memory bus.
- Holds 2^IDX_W one-word lines, each with a valid bit, a tag and data.
- Turns CPU read misses and all CPU writes into single-word memory transactions using a req/ack handshake.
- Keeps saturating hit and miss counters for the performance test bench.

Parameters:
- ADDR_W, 8, CPU/memory word address width.
- DATA_W, 8, data word width.
- IDX_W, 3, index width; the cache has 2^IDX_W lines; tag width = ADDR_W-IDX_W.
- CNT_W, 16, hit/miss counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU request valid; held high until cpu_ready.
- cpu_rw  in  1  1=read, 0=write.
- cpu_addr  in  ADDR_W  word address; index=addr[IDX_W-1:0], tag=upper bits.
- cpu_wdata  in  DATA_W  write data.
- cpu_flush  in  1  invalidate all lines; honoured only in IDLE.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request, held until mem_ack.
- mem_rw  out  1  1=read, 0=write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion, one cycle.
- hit_cnt  out  CNT_W  saturating hit count.
- miss_cnt  out  CNT_W  saturating miss count.

Behaviour:
- Reset (asynchronous, immediate):
  - All valid bits = 0; state = IDLE.
  - Outputs cpu_ready, mem_req, cpu_rdata, mem_addr, mem_wdata, hit_cnt and miss_cnt = 0; mem_rw = 1.
  - Reset mid-transaction aborts it: mem_req drops without waiting for mem_ack, and no line is updated.
- States: IDLE, LOOKUP, MEM_RD, MEM_WR, RESP.
- IDLE:
  - cpu_flush=1 clears all valid bits in one cycle and stays in IDLE.
  - If cpu_flush=1 and cpu_req=1 together, the flush wins and the request is taken next cycle.
  - Otherwise cpu_req=1 latches rw, addr and wdata into request registers, then goes to LOOKUP.
- LOOKUP: hit = valid[idx] && tag[idx]==req_tag.
  - Read hit: cpu_rdata <= data[idx]; hit_cnt+1; go to RESP.
  - Read miss: miss_cnt+1; go to MEM_RD.
  - Write hit: data[idx] <= wdata; hit_cnt+1; go to MEM_WR.
  - Write miss: line untouched; miss_cnt+1; go to MEM_WR.
- MEM_RD: mem_req=1, mem_rw=1, mem_addr=req_addr, all stable until mem_ack.
  - On mem_ack: valid[idx]=1, tag[idx]=req_tag, data[idx]=mem_rdata, cpu_rdata<=mem_rdata; deassert mem_req next cycle; go to RESP.
- MEM_WR: mem_req=1, mem_rw=0, mem_addr/mem_wdata = request values, stable until mem_ack; on mem_ack go to RESP.
- RESP: cpu_ready=1 for exactly one cycle, then IDLE. cpu_rdata holds its value until the next read completes.
- Latency from the cpu_req capture edge to cpu_ready:
  - Read hit: 2 cycles.
  - Miss or write: 3 + memory wait cycles; mem_ack in the first MEM cycle gives 3.
- mem_ack outside MEM_RD/MEM_WR is ignored.
- cpu_req is ignored outside IDLE. A CPU that keeps cpu_req high in the cycle after cpu_ready issues a new request.
- Counters saturate at all-ones and do not wrap.
- cpu_flush outside IDLE is ignored, not queued.

Decomposition:
- Package dm_cache_pkg:
  - State enum with IDLE/LOOKUP/MEM_RD/MEM_WR/RESP.
  - RW_READ=1 and RW_WRITE=0 constants.
  - Function deriving tag width from ADDR_W and IDX_W.
- One natural sub-module, dm_cache_array, holding the valid, tag and data storage:
  - Combinational read by index.
  - Synchronous write with a fill/update enable.
  - Single-cycle flush that clears all valid bits.
  - Asynchronous reset of the valid bits.

Test Plan:
- Reset, then read addr 0x13 with mem_ack after 2 wait cycles and mem_rdata=0xA5 -> mem_req held 3 cycles with mem_addr=0x13, mem_rw=1; cpu_ready with cpu_rdata=0xA5; miss_cnt=1.
- Read 0x13 again -> no mem_req; cpu_ready 2 cycles after capture with 0xA5; hit_cnt=1.
- Write 0x13 with 0x3C -> hit; mem_req with mem_rw=0, mem_wdata=0x3C; after ack, read 0x13 returns 0x3C with no memory traffic.
- Write miss at 0x2B, then read 0x2B -> the write goes to memory, the read misses (miss_cnt +2), showing no allocate on write.
- Read 0x13 then 0x1B (same index, different tag) -> second read misses and evicts; re-reading 0x13 misses again.
- Fill line 0x13, pulse cpu_flush in IDLE, read 0x13 -> misses. Separately, assert rst_n=0 during MEM_RD wait -> mem_req low immediately; after reset the read of 0x13 misses and both counters are 0.
